// File: rtl/hilo_ctrl.sv
// hilo_ctrl: HI/LO register control, sequencing long mul/div ops through an external arithmetic unit.
// Compile-time option MADD_MSUB_EN adds the multiply-accumulate ACC state and 64-bit product register.
module hilo_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic [3:0]  req_op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        flush,
    output logic        stall,
    output logic [3:0]  unit_op,
    output logic [31:0] unit_a,
    output logic [31:0] unit_b,
    output logic        unit_flush,
    input  logic [31:0] unit_hi,
    input  logic [31:0] unit_lo,
    input  logic        unit_ok,
    output logic [31:0] mf_data,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);
    localparam logic [3:0] OP_NOP   = 4'd0;
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MFHI  = 4'd7;
    localparam logic [3:0] OP_MFLO  = 4'd8;
`ifdef MADD_MSUB_EN
    localparam logic [3:0] OP_MADD  = 4'd9;
    localparam logic [3:0] OP_MADDU = 4'd10;
    localparam logic [3:0] OP_MSUBU = 4'd12;

    typedef enum logic [1:0] {IDLE, BUSY, ACC} state_t;

    function automatic logic is_mac(input logic [3:0] op);
        return op inside {[OP_MADD:OP_MSUBU]};
    endfunction

    function automatic logic is_long(input logic [3:0] op);
        return op inside {[OP_MULT:OP_DIVU], [OP_MADD:OP_MSUBU]};
    endfunction
`else
    typedef enum logic {IDLE, BUSY} state_t;

    function automatic logic is_long(input logic [3:0] op);
        return op inside {[OP_MULT:OP_DIVU]};
    endfunction
`endif

    state_t      state_q;
    logic [3:0]  op_q;
    logic [31:0] a_q, b_q, hi_q, lo_q;
    logic        req_go, busy, in_acc;
`ifdef MADD_MSUB_EN
    logic [63:0] prod_q;
    assign in_acc = state_q == ACC;
`else
    assign in_acc = 1'b0;
`endif

    assign busy       = state_q == BUSY;
    assign req_go     = req_valid & ~flush & (state_q == IDLE);
    assign stall      = ~flush & (busy ? ~unit_ok : in_acc | (req_go & is_long(req_op)));
    // The unit only ever sees a live op while BUSY, so it cannot restart on a stale one.
    assign unit_op    = (busy & ~flush) ? op_q : OP_NOP;
    assign unit_a     = a_q;
    assign unit_b     = b_q;
    assign unit_flush = flush;
    assign mf_data    = ~req_go ? 32'd0 : req_op == OP_MFHI ? hi_q : req_op == OP_MFLO ? lo_q : 32'd0;
    assign hi_o       = hi_q;
    assign lo_o       = lo_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            op_q    <= OP_NOP;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
`ifdef MADD_MSUB_EN
            prod_q  <= '0;
`endif
        end else if (flush) begin
            state_q <= IDLE;
        end else begin
            case (state_q)
                IDLE: if (req_valid) begin
                    if (is_long(req_op)) begin
                        state_q <= BUSY;
                        op_q    <= req_op;
                        a_q     <= src_a;
                        b_q     <= src_b;
                    end
                    if (req_op == OP_MTHI) hi_q <= src_a;
                    if (req_op == OP_MTLO) lo_q <= src_a;
                end
                BUSY: if (unit_ok) begin
`ifdef MADD_MSUB_EN
                    if (is_mac(op_q)) begin
                        prod_q  <= {unit_hi, unit_lo};
                        state_q <= ACC;
                    end else
`endif
                    begin
                        {hi_q, lo_q} <= {unit_hi, unit_lo};
                        state_q      <= IDLE;
                    end
                end
`ifdef MADD_MSUB_EN
                ACC: begin
                    {hi_q, lo_q} <= (op_q inside {OP_MADD, OP_MADDU}) ? {hi_q, lo_q} + prod_q
                                                                       : {hi_q, lo_q} - prod_q;
                    state_q      <= IDLE;
                end
`endif
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule
